// File: rtl/fpga_edge_pkg.sv
// Shared geometry, configuration field offsets and pad map for the FPGA edge block.
package fpga_edge_pkg;
  localparam int TILES    = 8;
  localparam int TPT      = 4;
  localparam int TRACKS   = 32;
  localparam int NPADS    = 10;
  localparam int CFG_BITS = 226;

  localparam int SIDE_PADS = 5;
  localparam int CB_W      = 3;
  localparam int DRV_W     = 2;
  localparam int PAD_W     = 5;

  localparam int CB_L_BASE  = 0;
  localparam int CB_B_BASE  = 24;
  localparam int DRV_L_BASE = 48;
  localparam int DRV_B_BASE = 112;
  localparam int PAD_BASE   = 176;

  // Row/column to side-local pad index; bottom pads are offset by SIDE_PADS.
  localparam logic [2:0] PAD_MAP [TILES] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
endpackage

// File: rtl/fpga_edge_conn_cfg_chain.sv
// Serial configuration shift register with enable and asynchronous clear.
module conn_cfg_chain
  import fpga_edge_pkg::*;
(
  input  logic                scan_clk,
  input  logic                reset,
  input  logic                scan_en,
  input  logic                scan_in,
  output logic [CFG_BITS-1:0] cfg
);
  logic [CFG_BITS-1:0] cfg_q;
  logic [CFG_BITS-1:0] cfg_d;

  always_comb begin
    cfg_d = cfg_q;
    if (scan_en) cfg_d = {cfg_q[CFG_BITS-2:0], scan_in};
  end

  always_ff @(posedge scan_clk or negedge reset) begin
    if (!reset) cfg_q <= '0;
    else        cfg_q <= cfg_d;
  end

  assign cfg = cfg_q;
endmodule

// File: rtl/fpga_edge.sv
// FPGA array edge: left/bottom connection boxes, track drivers and pad outputs,
// all combinational from the scan-loaded configuration.
module fpga_edge
  import fpga_edge_pkg::*;
(
  input  logic              scan_clk,
  input  logic              reset,
  input  logic              conn_scan_en,
  input  logic              conn_scan_in,
  output logic              conn_scan_out,
  input  logic [TRACKS-1:0] right_in,
  output logic [TRACKS-1:0] right_out,
  input  logic [TRACKS-1:0] top_in,
  output logic [TRACKS-1:0] top_out,
  input  logic [TILES-1:0]  right_sb_in,
  output logic [TILES-1:0]  right_clb_in,
  output logic [TILES-1:0]  top_clb_in,
  input  logic [NPADS-1:0]  fpga_in,
  output logic [NPADS-1:0]  fpga_out,
  input  logic [TPT-1:0]    right_dummy_in
);
  logic [CFG_BITS-1:0] cfg;

  conn_cfg_chain u_chain (
    .scan_clk (scan_clk),
    .reset    (reset),
    .scan_en  (conn_scan_en),
    .scan_in  (conn_scan_in),
    .cfg      (cfg)
  );

  assign conn_scan_out = cfg[CFG_BITS-1];

  genvar gi;

  // Connection boxes: sel[2] picks the outgoing track bundle over the incoming one.
  for (gi = 0; gi < TILES; gi++) begin : g_cb
    logic [CB_W-1:0] lsel;
    logic [CB_W-1:0] bsel;
    logic [TPT-1:0]  l_in;
    logic [TPT-1:0]  l_out;
    logic [TPT-1:0]  b_in;
    logic [TPT-1:0]  b_out;

    assign lsel  = cfg[CB_L_BASE + CB_W*gi +: CB_W];
    assign bsel  = cfg[CB_B_BASE + CB_W*gi +: CB_W];
    assign l_in  = right_in[TPT*gi +: TPT];
    assign l_out = right_out[TPT*gi +: TPT];
    assign b_in  = top_in[TPT*gi +: TPT];
    assign b_out = top_out[TPT*gi +: TPT];

    assign right_clb_in[gi] = lsel[2] ? l_out[lsel[1:0]] : l_in[lsel[1:0]];
    assign top_clb_in[gi]   = bsel[2] ? b_out[bsel[1:0]] : b_in[bsel[1:0]];
  end

  for (gi = 0; gi < TRACKS; gi++) begin : g_trk
    localparam int ROW  = gi / TPT;
    localparam int LPAD = int'(PAD_MAP[ROW]);
    localparam int BPAD = SIDE_PADS + LPAD;

    logic [DRV_W-1:0] ls;
    logic [DRV_W-1:0] bs;
    logic [3:0]       l_opts;
    logic [3:0]       b_opts;

    assign ls     = cfg[DRV_L_BASE + DRV_W*gi +: DRV_W];
    assign bs     = cfg[DRV_B_BASE + DRV_W*gi +: DRV_W];
    assign l_opts = {right_in[gi], fpga_in[LPAD], right_sb_in[ROW], 1'b0};
    assign b_opts = {right_dummy_in[gi % TPT], top_in[gi], fpga_in[BPAD], 1'b0};

    assign right_out[gi] = l_opts[ls];
    assign top_out[gi]   = b_opts[bs];
  end

  for (gi = 0; gi < NPADS; gi++) begin : g_pad
    logic [PAD_W-1:0] idx;
    assign idx = cfg[PAD_BASE + PAD_W*gi +: PAD_W];
    if (gi < SIDE_PADS) begin : g_left
      assign fpga_out[gi] = right_in[idx];
    end else begin : g_bottom
      assign fpga_out[gi] = top_in[idx];
    end
  end
endmodule

// File: tb/tb_fpga_edge.sv
// Directed self-checking bench for fpga_edge: reset, chain length, routing paths, mid-shift reset.
module tb_fpga_edge;
  logic        scan_clk;
  logic        reset;
  logic        conn_scan_en;
  logic        conn_scan_in;
  logic        conn_scan_out;
  logic [31:0] right_in;
  logic [31:0] right_out;
  logic [31:0] top_in;
  logic [31:0] top_out;
  logic [7:0]  right_sb_in;
  logic [7:0]  right_clb_in;
  logic [7:0]  top_clb_in;
  logic [9:0]  fpga_in;
  logic [9:0]  fpga_out;
  logic [3:0]  right_dummy_in;

  int n_pass;
  int n_total;

  fpga_edge dut (
    .scan_clk       (scan_clk),
    .reset          (reset),
    .conn_scan_en   (conn_scan_en),
    .conn_scan_in   (conn_scan_in),
    .conn_scan_out  (conn_scan_out),
    .right_in       (right_in),
    .right_out      (right_out),
    .top_in         (top_in),
    .top_out        (top_out),
    .right_sb_in    (right_sb_in),
    .right_clb_in   (right_clb_in),
    .top_clb_in     (top_clb_in),
    .fpga_in        (fpga_in),
    .fpga_out       (fpga_out),
    .right_dummy_in (right_dummy_in)
  );

  initial scan_clk = 1'b0;
  always #5 scan_clk = ~scan_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Shift a full configuration image; v[225] goes in first so it lands in cfg[225].
  task automatic load_cfg(input logic [225:0] v);
    for (int i = 225; i >= 0; i--) begin
      conn_scan_in = v[i];
      conn_scan_en = 1'b1;
      @(negedge scan_clk);
    end
    conn_scan_en = 1'b0;
    conn_scan_in = 1'b0;
  endtask

  logic [225:0] img;

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    conn_scan_en = 1'b1;
    conn_scan_in = 1'b1;
    right_in = 32'h1111_1111;
    top_in = 32'h0000_0001;
    right_sb_in = 8'hFF;
    fpga_in = 10'h3FF;
    right_dummy_in = 4'hF;

    // Reset held with clock running and enable high
    repeat (3) @(negedge scan_clk);
    chk("rst_scan_out", 32'(conn_scan_out), 32'h0);
    chk("rst_right_out", right_out, 32'h0);
    chk("rst_top_out", top_out, 32'h0);
    chk("rst_right_clb_a", 32'(right_clb_in), 32'hFF);
    chk("rst_top_clb_a", 32'(top_clb_in), 32'h01);
    chk("rst_fpga_out_a", 32'(fpga_out), 32'h3FF);
    right_in = 32'h0101_0110;
    top_in = 32'h1000_0010;
    #1;
    chk("rst_right_clb_b", 32'(right_clb_in), 32'h56);
    chk("rst_top_clb_b", 32'(top_clb_in), 32'h82);
    chk("rst_fpga_out_b", 32'(fpga_out), 32'h000);

    @(negedge scan_clk);
    reset = 1'b1;
    conn_scan_en = 1'b0;
    conn_scan_in = 1'b0;
    right_in = 32'h0;
    top_in = 32'h0;
    right_sb_in = 8'h0;
    fpga_in = 10'h0;
    right_dummy_in = 4'h0;
    @(negedge scan_clk);

    // Chain length: one 1 followed by 225 zeros
    for (int i = 0; i < 226; i++) begin
      conn_scan_in = (i == 0);
      conn_scan_en = 1'b1;
      @(negedge scan_clk);
      if (i == 224) chk("chain_225_edges", 32'(conn_scan_out), 32'h0);
    end
    chk("chain_226_edges", 32'(conn_scan_out), 32'h1);
    conn_scan_en = 1'b0;
    conn_scan_in = 1'b0;
    repeat (10) @(negedge scan_clk);
    chk("chain_hold", 32'(conn_scan_out), 32'h1);

    // Pad to track: left t5 s=2 (pad 0), left t30 s=2 (pad 4), bottom t25 s=1 (pad 8)
    img = '0;
    img[59:58]   = 2'd2;
    img[109:108] = 2'd2;
    img[163:162] = 2'd1;
    load_cfg(img);
    fpga_in = 10'h000;
    #1;
    chk("pad_trk_r0", right_out, 32'h0);
    fpga_in = 10'h001;
    #1;
    chk("pad_trk_r1", right_out, 32'h0000_0020);
    chk("pad_trk_t1", top_out, 32'h0);
    fpga_in = 10'h110;
    #1;
    chk("pad_trk_r2", right_out, 32'h4000_0000);
    chk("pad_trk_t2", top_out, 32'h0200_0000);
    fpga_in = 10'h000;
    #1;
    chk("pad_trk_r3", right_out, 32'h0);
    @(negedge scan_clk);

    // Connection box: row 3 sel=6 reads right_out[14], driven by right_sb_in[3]
    img = '0;
    img[11:9]  = 3'd6;
    img[77:76] = 2'd1;
    load_cfg(img);
    right_sb_in = 8'h08;
    #1;
    chk("cb_row3_hi", 32'(right_clb_in), 32'h08);
    chk("cb_trk14_hi", right_out, 32'h0000_4000);
    right_sb_in = 8'hF7;
    #1;
    chk("cb_row3_lo", 32'(right_clb_in), 32'h00);
    chk("cb_trk14_lo", right_out, 32'h0);
    right_sb_in = 8'h0;
    @(negedge scan_clk);

    // Pad output 7 idx=17, bottom t9 s=3 (dummy 1), bottom CB col 2 sel=1
    img = '0;
    img[215:211] = 5'd17;
    img[131:130] = 2'd3;
    img[32:30]   = 3'd1;
    load_cfg(img);
    top_in = 32'h0002_0200;
    right_dummy_in = 4'b0010;
    #1;
    chk("pad7_hi", 32'(fpga_out), 32'h080);
    chk("bot_trk9_hi", top_out, 32'h0000_0200);
    chk("bot_cb_col2", 32'(top_clb_in), 32'h04);
    top_in = 32'h0;
    right_dummy_in = 4'b1101;
    #1;
    chk("pad7_lo", 32'(fpga_out), 32'h000);
    chk("bot_trk9_lo", top_out, 32'h0);
    @(negedge scan_clk);

    // Mid-shift reset after 100 ones
    right_in = 32'hFFFF_FFFF;
    top_in = 32'h0000_0001;
    right_sb_in = 8'hFF;
    fpga_in = 10'h3FF;
    right_dummy_in = 4'hF;
    for (int i = 0; i < 100; i++) begin
      conn_scan_in = 1'b1;
      conn_scan_en = 1'b1;
      @(negedge scan_clk);
    end
    chk("mid_pre_right_out", 32'(right_out != 32'h0), 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_scan_out", 32'(conn_scan_out), 32'h0);
    chk("mid_rst_right_out", right_out, 32'h0);
    chk("mid_rst_top_out", top_out, 32'h0);
    chk("mid_rst_right_clb", 32'(right_clb_in), 32'hFF);
    chk("mid_rst_top_clb", 32'(top_clb_in), 32'h01);
    chk("mid_rst_fpga_out", 32'(fpga_out), 32'h3FF);
    @(negedge scan_clk);
    reset = 1'b1;
    conn_scan_in = 1'b0;
    for (int i = 0; i < 130; i++) begin
      conn_scan_en = 1'b1;
      @(negedge scan_clk);
    end
    conn_scan_en = 1'b0;
    chk("mid_resume_zero", 32'(conn_scan_out), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fpga_edge.md
FPGA_EDGE -- requirements
Module: fpga_edge

Interface
REQ-001 Parameters: none; geometry fixed at 8 tiles per side, 4 tracks per tile, 32 tracks per side, 10 pads, 226 configuration bits.
REQ-002 scan_clk  in  1  the only clock; configuration shift clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low; clears the configuration.
REQ-004 conn_scan_en  in  1  shift enable.
REQ-005 conn_scan_in  in  1  serial configuration in.
REQ-006 conn_scan_out  out  1  serial configuration out, equal to cfg[225].
REQ-007 right_in  in  32  tracks driven by the array's left edge; track t belongs to row t/4.
REQ-008 right_out  out  32  tracks driven into the array's left edge.
REQ-009 top_in  in  32  tracks driven by the array's bottom edge; track t belongs to column t/4.
REQ-010 top_out  out  32  tracks driven into the array's bottom edge.
REQ-011 right_sb_in  in  8  left-column CLB outputs, one per row.
REQ-012 right_clb_in  out  8  left connection-box outputs feeding left-column CLB inputs.
REQ-013 top_clb_in  out  8  bottom connection-box outputs feeding bottom-row CLB inputs.
REQ-014 fpga_in  in  10  pad inputs; pads 0-4 are on the left side, pads 5-9 on the bottom side.
REQ-015 fpga_out  out  10  pad outputs.
REQ-016 right_dummy_in  in  4  corner auxiliary inputs.

Function
REQ-017 Configuration register cfg[225:0]: on scan_clk rise with conn_scan_en=1, cfg[0]<=conn_scan_in and cfg[i]<=cfg[i-1]; with conn_scan_en=0, cfg holds.
REQ-018 Loading order: the first bit shifted in ends in cfg[225]; within each field, the lower cfg index is the value LSB.
REQ-019 Datapath is purely combinational from cfg and the inputs; there is no shadow register, so outputs follow cfg during shifting.
REQ-020 Pad map: L[r] = {0,0,1,1,2,2,3,4} for r=0..7; left row r uses pad L[r]; bottom column c uses pad 5+L[c].
REQ-021 Left connection box, row r, sel=cfg[3r+2:3r]:
- sel 0-3: right_clb_in[r] = right_in[4r+sel].
- sel 4-7: right_clb_in[r] = right_out[4r+sel-4].
REQ-022 Bottom connection box, column c, sel=cfg[24+3c+2:24+3c]: same rule as REQ-021 using top_in/top_out, driving top_clb_in[c].
REQ-023 Left track driver t (row r=t/4), s=cfg[48+2t+1:48+2t]: right_out[t] = 0 / right_sb_in[r] / fpga_in[L[r]] / right_in[t] for s = 0/1/2/3.
REQ-024 Bottom track driver t (column c=t/4, k=t%4), s=cfg[112+2t+1:112+2t]: top_out[t] = 0 / fpga_in[5+L[c]] / top_in[t] / right_dummy_in[k] for s = 0/1/2/3.
REQ-025 Pad output p, idx=cfg[176+5p+4:176+5p]: fpga_out[p] = right_in[idx] for p<5, top_in[idx] for p>=5.
REQ-026 Simultaneous shifting and input changes: outputs reflect the current cfg and inputs with no glitch filtering.

Reset
REQ-027 reset=0 asynchronously sets cfg to all zeros regardless of scan_clk or conn_scan_en.
REQ-028 Resulting outputs: conn_scan_out=0, right_out=0, top_out=0, right_clb_in[r]=right_in[4r], top_clb_in[c]=top_in[4c], fpga_out[0..4]=right_in[0], fpga_out[5..9]=top_in[0].
REQ-029 Reset asserted mid-shift discards partial configuration; shifting resumes from zero after release.

Structure
REQ-030 Shared package holds: TILES=8, TPT=4, TRACKS=32, NPADS=10, CFG_BITS=226, field base offsets (0, 24, 48, 112, 176), and the pad-map table L.
REQ-031 One sub-module, conn_cfg_chain: the 226-bit shift register with enable and asynchronous clear; the muxes stay in fpga_edge.

Verification
REQ-032 Reset: hold reset=0, pulse scan_clk -> cfg stays all zero and outputs match REQ-028.
REQ-033 Chain length: shift a single 1 then 225 zeros with en=1 -> conn_scan_out=1 exactly after the 226th edge; 10 further edges with en=0 -> still 1.
REQ-034 Pad to track: left driver 5 set to s=2 -> right_out[5] follows fpga_in[0] 0->1->0.
REQ-035 Connection box: row-3 CB sel=6 and left driver 14 s=1 -> right_clb_in[3]=right_sb_in[3] for both values.
REQ-036 Pad output: pad 7 idx=17, bottom driver 9 s=3 -> fpga_out[7]=top_in[17] and top_out[9]=right_dummy_in[1].
REQ-037 Mid-shift reset: reset=0 after 100 shift edges -> all outputs return to REQ-028 values immediately.
